// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_gen
// Purpose  : 640x480 VGA raster generator with multiplier-free scaled
//            tile-source coordinates and index-ROM address.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int TILE_W   = 48,
   parameter int TILE_H   = 64
) (
   input  logic        vga_clk,
   input  logic        reset_n,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic        sync,
   output logic        line_start,
   output logic        frame_start,
   output logic [5:0]  src_col,
   output logic [6:0]  src_row,
   output logic [12:0] src_addr
);

   localparam logic [9:0]  c_H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]  c_V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]  c_HS_BEG   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  c_VS_BEG   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0]  c_HA       = 10'(H_ACTIVE);
   localparam logic [9:0]  c_VA       = 10'(V_ACTIVE);
   localparam logic [9:0]  c_TW10     = 10'(TILE_W);
   localparam logic [9:0]  c_TH10     = 10'(TILE_H);
   localparam logic [12:0] c_TW13     = 13'(TILE_W);

   // r_run is low for the first edge after reset so that edge presents (0,0)
   logic        r_run;
   logic [9:0]  r_rx;
   logic [5:0]  r_col;
   logic [9:0]  r_ry;
   logic [6:0]  r_row;
   logic [12:0] r_base;

   logic [9:0]  w_nx;
   logic [9:0]  w_ny;
   logic [9:0]  w_rx_sum;
   logic [9:0]  w_rx_nx;
   logic [5:0]  w_col_nx;
   logic [9:0]  w_ry_sum;
   logic [9:0]  w_ry_nx;
   logic [6:0]  w_row_nx;
   logic [12:0] w_base_nx;
   logic        w_vis;

   always_comb begin
      w_nx = '0;
      w_ny = '0;
      if (r_run) begin
         if (DrawX == c_H_LAST) begin
            w_nx = '0;
            w_ny = (DrawY == c_V_LAST) ? 10'd0 : DrawY + 10'd1;
         end else begin
            w_nx = DrawX + 10'd1;
            w_ny = DrawY;
         end
      end

      w_rx_sum = r_rx + c_TW10;
      w_rx_nx  = '0;
      w_col_nx = '0;
      if ((w_nx != 10'd0) && (w_nx < c_HA)) begin
         if (w_rx_sum >= c_HA) begin
            w_rx_nx  = w_rx_sum - c_HA;
            w_col_nx = r_col + 6'd1;
         end else begin
            w_rx_nx  = w_rx_sum;
            w_col_nx = r_col;
         end
      end

      // Row state only moves on the first pixel of a line
      w_ry_sum  = r_ry + c_TH10;
      w_ry_nx   = r_ry;
      w_row_nx  = r_row;
      w_base_nx = r_base;
      if (w_nx == 10'd0) begin
         if ((w_ny == 10'd0) || (w_ny >= c_VA)) begin
            w_ry_nx   = '0;
            w_row_nx  = '0;
            w_base_nx = '0;
         end else if (w_ry_sum >= c_VA) begin
            w_ry_nx   = w_ry_sum - c_VA;
            w_row_nx  = r_row + 7'd1;
            w_base_nx = r_base + c_TW13;
         end else begin
            w_ry_nx   = w_ry_sum;
         end
      end

      w_vis = (w_nx < c_HA) && (w_ny < c_VA);
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         r_run       <= 1'b0;
         r_rx        <= '0;
         r_col       <= '0;
         r_ry        <= '0;
         r_row       <= '0;
         r_base      <= '0;
         DrawX       <= '0;
         DrawY       <= '0;
         hs          <= 1'b1;
         vs          <= 1'b1;
         blank       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         src_col     <= '0;
         src_row     <= '0;
         src_addr    <= '0;
      end else begin
         r_run       <= 1'b1;
         r_rx        <= w_rx_nx;
         r_col       <= w_col_nx;
         r_ry        <= w_ry_nx;
         r_row       <= w_row_nx;
         r_base      <= w_base_nx;
         DrawX       <= w_nx;
         DrawY       <= w_ny;
         hs          <= !((w_nx >= c_HS_BEG) && (w_nx < c_HS_END));
         vs          <= !((w_ny >= c_VS_BEG) && (w_ny < c_VS_END));
         blank       <= w_vis;
         line_start  <= (w_nx == 10'd0);
         frame_start <= (w_nx == 10'd0) && (w_ny == 10'd0);
         src_col     <= w_vis ? w_col_nx : 6'd0;
         src_row     <= w_vis ? w_row_nx : 7'd0;
         src_addr    <= w_vis ? (w_base_nx + {7'd0, w_col_nx}) : 13'd0;
      end
   end

   assign sync = 1'b0;

endmodule
`default_nettype wire

// File: doc/vga_scan_gen.md
# vga_scan_gen

Free-running VGA raster generator for the 640x480 display path, on `vga_clk`. It drives the pixel coordinates, blanking and sync consumed by the sprite and tile mappers. It also produces pre-scaled tile-source coordinates and a ROM address for a TILE_W x TILE_H index image. These are computed incrementally with remainder accumulators, so downstream mappers need no multiplier or divider. It sits between the pixel-clock source and every mapper/palette stage.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- TILE_W, 48, source image width; must be < H_ACTIVE
- TILE_H, 64, source image height; must be < V_ACTIVE
- vga_clk  in  1  pixel clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- DrawX  out  10  current horizontal position, 0..H_total-1
- DrawY  out  10  current line, 0..V_total-1
- hs  out  1  horizontal sync, active low
- vs  out  1  vertical sync, active low
- blank  out  1  1 = active video (DrawX<H_ACTIVE and DrawY<V_ACTIVE), 0 = blanked
- sync  out  1  composite sync, constant 0
- line_start  out  1  1 when DrawX==0
- frame_start  out  1  1 when DrawX==0 and DrawY==0
- src_col  out  6  floor(DrawX*TILE_W/H_ACTIVE) in the visible region, else 0
- src_row  out  7  floor(DrawY*TILE_H/V_ACTIVE) in the visible region, else 0
- src_addr  out  13  src_row*TILE_W + src_col

## Operation
- H_total = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_total = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal counter increments every cycle and wraps at H_total-1 to 0.
- Vertical counter increments on each horizontal wrap and wraps at V_total-1 to 0.
- hs=0 iff H_ACTIVE+H_FP <= DrawX < H_ACTIVE+H_FP+H_SYNC, i.e. [656,752).
- vs=0 iff V_ACTIVE+V_FP <= DrawY < V_ACTIVE+V_FP+V_SYNC, i.e. [490,492).
- Column accumulator: remainder rx starts at 0 with col=0 at DrawX=0.
  - Each visible step: rx+TILE_W; if the sum >= H_ACTIVE, subtract H_ACTIVE and increment col. At most one subtraction, since TILE_W<H_ACTIVE.
  - When DrawX reaches H_ACTIVE, col and rx reset to 0.
- Row accumulator: same scheme, with ry, TILE_H and V_ACTIVE, advanced on each horizontal wrap.
  - row_base tracks src_row*TILE_W by adding TILE_W whenever row increments.
  - row, ry and row_base reset to 0 when DrawY reaches V_ACTIVE, and again at frame wrap.
- src_addr = row_base + col. No multiplier or divider anywhere in the block.
- Results must equal the exact floor formulas for every visible pixel.

## Timing
- All outputs are registered. DrawX, DrawY, hs, vs, blank, line_start, frame_start and src_* describe the same pixel in the same cycle, with zero skew between them.
- Reset: on any edge with reset_n=0, outputs take these values:
  - DrawX=0, DrawY=0
  - hs=1, vs=1
  - blank=0, sync=0
  - line_start=0, frame_start=0
  - src_col=0, src_row=0, src_addr=0
- First edge with reset_n=1: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1.
- Each later edge advances one pixel.
- Reset asserted mid-frame aborts the frame. The edge after release restarts at (0,0) as above; no partial sync pulse is completed.
- Line period is exactly H_total cycles; frame period is exactly H_total*V_total cycles (420000).
- frame_start pulses once per frame; line_start pulses once per line, including blanked lines.

## Test plan
- Reset hold 5 cycles, then release:
  - During reset: hs=vs=1, blank=0.
  - First released cycle: (0,0), blank=1, frame_start=1, src_addr=0.
  - 420000 cycles later: frame_start=1 again.
- Horizontal timing on line 0:
  - blank falls at DrawX=640.
  - hs=0 for exactly DrawX 656..751.
  - line_start recurs every 800 cycles.
- Column scaling:
  - DrawX=13 gives src_col=0; DrawX=14 gives 1.
  - DrawX=639 gives 47.
  - DrawX=640..799 gives 0.
  - A full sweep of all visible X must match floor(x*48/640).
- Row scaling and address:
  - DrawY=7 gives src_row=0; DrawY=8 gives 1.
  - (639,479) gives src_row=63, src_addr=3071.
  - DrawY>=480 gives src_row=0, blank=0.
  - Exhaustive comparison of src_addr against the formula over one frame.
- Vertical timing: vs=0 exactly for lines 490–491 (1600 cycles); DrawY wraps 524 to 0 with frame_start=1.
- Mid-frame reset at (300,200) for 2 cycles:
  - Outputs take reset values.
  - The restart at (0,0) has correct accumulators: DrawX=14 gives src_col=1.
